window3x3_stream: RTL

//  Streaming 3x3 neighbourhood generator for the convolution datapath. Accepts one pixel per

---
 rtl/window3x3_stream.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/window3x3_stream.sv
// Streaming 3x3 window generator: two line buffers plus a two-column shift register build each interior window.
// Optional macro WIN_OUT_REG_EN adds a second output stage (2-entry pipe, latency 2).
module window3x3_stream #(
    parameter int DW    = 8,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_pixel,
    input  logic            in_sof,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [9*DW-1:0] win_o,
    output logic [15:0]     out_row,
    output logic [15:0]     out_col,
    output logic            frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW = 9*DW + 32;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [DW-1:0]   lb0_mem [IMG_W];
    logic [DW-1:0]   lb1_mem [IMG_W];
    logic [DW-1:0]   lb0_rd, lb1_rd;
    logic [CW-1:0]   col_q, col_d, col_eff, col_ctr;
    logic [RW-1:0]   row_q, row_d, row_eff, row_ctr;
    logic [3*DW-1:0] c1_q, c1_d, c2_q, c2_d;
    logic            accept, emit;
    logic            frame_done_q, frame_done_d;
    logic [9*DW-1:0] win_new;
    logic [PW-1:0]   payload_new;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   out_pl_q, out_pl_d;

    assign accept  = in_valid && in_ready;
    // in_sof overrides the counters so a frame can restart at any point
    assign col_eff = in_sof ? '0 : col_q;
    assign row_eff = in_sof ? '0 : row_q;
    assign lb0_rd  = lb0_mem[col_eff];
    assign lb1_rd  = lb1_mem[col_eff];
    assign col_ctr = col_eff - COL_ONE;
    assign row_ctr = row_eff - ROW_ONE;
    assign emit    = accept && (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);

    // Shift-register columns are packed {bottom, middle, top}
    assign win_new = {in_pixel, c1_q[3*DW-1:2*DW], c2_q[3*DW-1:2*DW],
                      lb0_rd,   c1_q[2*DW-1:DW],   c2_q[2*DW-1:DW],
                      lb1_rd,   c1_q[DW-1:0],      c2_q[DW-1:0]};
    assign payload_new = {16'(row_ctr), 16'(col_ctr), win_new};

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_mem[col_eff] <= in_pixel;
            lb1_mem[col_eff] <= lb0_rd;
        end
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        c1_d         = c1_q;
        c2_d         = c2_q;
        frame_done_d = 1'b0;
        if (accept) begin
            c1_d = {in_pixel, lb0_rd, lb1_rd};
            c2_d = c1_q;
            if (col_eff == COL_LAST) begin
                col_d = '0;
                row_d = (row_eff == ROW_LAST) ? '0 : row_eff + ROW_ONE;
            end else begin
                col_d = col_eff + COL_ONE;
                row_d = row_eff;
            end
            frame_done_d = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
        end
    end

`ifdef WIN_OUT_REG_EN
    logic          s1_valid_q, s1_valid_d;
    logic [PW-1:0] s1_pl_q, s1_pl_d;
    logic          s2_take;

    assign s2_take  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_take;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_pl_d     = s1_pl_q;
        out_valid_d = out_valid_q;
        out_pl_d    = out_pl_q;
        if (s2_take) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) out_pl_d = s1_pl_q;
            s1_valid_d = 1'b0;
        end
        if (emit) begin
            s1_valid_d = 1'b1;
            s1_pl_d    = payload_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_pl_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pl_q    <= s1_pl_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_pl_d    = out_pl_q;
        if (out_ready) out_valid_d = 1'b0;
        if (emit) begin
            out_valid_d = 1'b1;
            out_pl_d    = payload_new;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            c1_q         <= '0;
            c2_q         <= '0;
            frame_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pl_q     <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            frame_done_q <= frame_done_d;
            out_valid_q  <= out_valid_d;
            out_pl_q     <= out_pl_d;
        end
    end

    assign out_valid              = out_valid_q;
    assign frame_done             = frame_done_q;
    assign {out_row, out_col, win_o} = out_pl_q;
endmodule
